// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-ported data memory: registered round-robin grant
// with a burst cap. Define ARB_FIXED_PRIO_EN to favour master 0 (CPU) on ties and never preempt it.
module mem_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t             state, state_n;
    logic               last, last_n;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_n;
    logic               cap;

    assign cap = (burst_cnt == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            burst_cnt <= burst_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        last_n      = last;
        burst_cnt_n = burst_cnt;
        unique case (state)
            IDLE: begin
                if (m0_req && m1_req)
                    state_n = (FIXED_PRIO || last) ? OWN0 : OWN1;
                else if (m0_req)
                    state_n = OWN0;
                else if (m1_req)
                    state_n = OWN1;
            end
            OWN0: begin
                if (!m0_req)
                    state_n = m1_req ? OWN1 : IDLE;
                else if (m1_req && cap && !FIXED_PRIO)
                    state_n = OWN1;
            end
            OWN1: begin
                if (!m1_req)
                    state_n = m0_req ? OWN0 : IDLE;
                else if (m0_req && cap)
                    state_n = OWN0;
            end
            default: state_n = IDLE;
        endcase

        // Burst counter restarts on every ownership change and saturates while held.
        if (state_n != state) begin
            burst_cnt_n = '0;
            if (state_n == OWN0)
                last_n = 1'b0;
            else if (state_n == OWN1)
                last_n = 1'b1;
        end else if (state != IDLE && !cap) begin
            burst_cnt_n = burst_cnt + 1'b1;
        end
    end

    assign m0_gnt    = (state == OWN0) && m0_req;
    assign m1_gnt    = (state == OWN1) && m1_req;
    assign cpu_stall = m0_req && !m0_gnt;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        unique case (state)
            OWN0: begin
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                mem_we    = m0_we && m0_gnt;
            end
            OWN1: begin
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_we    = m1_we && m1_gnt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against an ownership/memory reference model.
module tb_mem_arbiter;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              arst_n;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr, mem_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic              m0_gnt, m1_gnt, mem_we, cpu_stall;

    int n_cmp = 0;
    int n_fail = 0;

    // Memory stub attached to the data port.
    logic [DATA_W-1:0] mem [0:127];
    logic              mem_init = 1'b0;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .arst_n(arst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
    );

    // Reference model: current owner (-1 none), last served, cycles held so far.
    int                m_own, m_last, m_held;
    logic [DATA_W-1:0] ref_mem [0:127];

    task automatic model_reset();
        m_own = -1; m_last = 1; m_held = 0;
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_step();
        int  nxt;
        bit  mine, oth;
        if (m_own == 0 && m0_req && m0_we) ref_mem[m0_addr] = m0_wdata;
        if (m_own == 1 && m1_req && m1_we) ref_mem[m1_addr] = m1_wdata;
        nxt = m_own;
        if (m_own < 0) begin
            if (m0_req && m1_req) nxt = (FIXED || m_last == 1) ? 0 : 1;
            else if (m0_req)      nxt = 0;
            else if (m1_req)      nxt = 1;
        end else begin
            mine = (m_own == 0) ? m0_req : m1_req;
            oth  = (m_own == 0) ? m1_req : m0_req;
            if (!mine) nxt = oth ? 1 - m_own : -1;
            else if (oth && m_held >= MAX_BURST && !(FIXED && m_own == 0)) nxt = 1 - m_own;
        end
        if (nxt != m_own) begin
            m_held = 1;
            if (nxt >= 0) m_last = nxt;
        end else if (nxt >= 0) begin
            m_held++;
        end
        m_own = nxt;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0, input logic r1, input logic w1,
                         input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        @(negedge clk);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        arst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        arst_n = 1'b0;
        m0_req = 1; m0_we = 1; m0_addr = 7'h11; m0_wdata = 32'h1234_5678;
        m1_req = 1; m1_we = 1; m1_addr = 7'h22; m1_wdata = 32'h8765_4321;
        #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b exp 00", {m0_gnt, m1_gnt}); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", mem_we); end
        n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_fail++; $display("FAIL reset_port got %h/%h exp 0/0", mem_addr, mem_wdata); end
        n_cmp++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b exp 1", cpu_stall); end
        reset_pulse();
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0, '0, 0, 0, '0, '0);
            n_cmp++; if ({m0_gnt, m1_gnt, mem_we, cpu_stall} !== 4'b0000 || mem_addr !== '0) begin
                n_fail++; $display("FAIL idle_after_reset got gnt=%b%b we=%b addr=%h exp all 0", m0_gnt, m1_gnt, mem_we, mem_addr);
            end
            model_step();
        end
    endtask

    task automatic test_single_master();
        drive(0, 0, '0, '0, 1, 1, 7'h05, 32'hDEADBEEF);
        n_cmp++; if (m1_gnt !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL single_latency got gnt=%b we=%b exp 0 0", m1_gnt, mem_we); end
        model_step();
        drive(0, 0, '0, '0, 1, 1, 7'h05, 32'hDEADBEEF);
        n_cmp++; if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 7'h05 || mem_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_write got gnt=%b we=%b addr=%h data=%h exp 1 1 05 deadbeef", m1_gnt, mem_we, mem_addr, mem_wdata);
        end
        model_step();
        drive(1, 0, 7'h05, '0, 0, 0, '0, '0);
        n_cmp++; if (mem_we !== 1'b0 || m0_gnt !== 1'b0 || cpu_stall !== 1'b1) begin
            n_fail++; $display("FAIL single_we_once got we=%b gnt0=%b stall=%b exp 0 0 1", mem_we, m0_gnt, cpu_stall);
        end
        model_step();
        drive(1, 0, 7'h05, '0, 0, 0, '0, '0);
        n_cmp++; if (m0_gnt !== 1'b1 || cpu_stall !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_readback got gnt0=%b stall=%b rdata=%h exp 1 0 deadbeef", m0_gnt, cpu_stall, m0_rdata);
        end
        model_step();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_step();
    endtask

    task automatic test_tie();
        reset_pulse();
        drive(1, 0, 7'h01, '0, 1, 0, 7'h02, '0);
        model_step();
        drive(1, 0, 7'h01, '0, 1, 0, 7'h02, '0);
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL tie_first got %b%b exp 10", m0_gnt, m1_gnt); end
        model_step();
        drive(0, 0, 7'h01, '0, 1, 0, 7'h02, '0);
        model_step();
        drive(0, 0, 7'h01, '0, 1, 0, 7'h02, '0);
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01 || mem_addr !== 7'h02) begin
            n_fail++; $display("FAIL tie_handover got %b%b addr=%h exp 01 addr=02", m0_gnt, m1_gnt, mem_addr);
        end
        model_step();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_step();
    endtask

    task automatic test_burst_cap();
        int g1 = 0, st = 0;
        reset_pulse();
        drive(0, 0, '0, '0, 1, 0, 7'h03, '0);
        model_step();
        for (int c = 0; c < 5; c++) begin
            drive(c >= 1, 0, 7'h04, '0, 1, 0, 7'h03, '0);
            if (m1_gnt === 1'b1) g1++;
            if (cpu_stall === 1'b1) st++;
            model_step();
        end
        drive(1, 0, 7'h04, '0, 1, 0, 7'h03, '0);
        n_cmp++; if (g1 !== MAX_BURST) begin n_fail++; $display("FAIL burst_len got %0d exp %0d", g1, MAX_BURST); end
        n_cmp++; if (st !== 3) begin n_fail++; $display("FAIL burst_stall got %0d exp 3", st); end
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL burst_preempt got %b%b exp 10", m0_gnt, m1_gnt); end
        model_step();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_step();
    endtask

    task automatic test_contention();
        int g0 = 0, sw = 0;
        logic prev = 1'b0;
        reset_pulse();
        drive(1, 0, '0, '0, 1, 0, '0, '0);
        model_step();
        for (int c = 0; c < 10; c++) begin
            drive(1, 0, '0, '0, 1, 0, '0, '0);
            if (m0_gnt === 1'b1) g0++;
            if (c > 0 && m0_gnt !== prev) sw++;
            prev = m0_gnt;
            model_step();
        end
        n_cmp++; if (g0 !== (FIXED ? 10 : 6)) begin n_fail++; $display("FAIL contention_m0 got %0d exp %0d", g0, FIXED ? 10 : 6); end
        n_cmp++; if (sw !== (FIXED ? 0 : 2)) begin n_fail++; $display("FAIL contention_switches got %0d exp %0d", sw, FIXED ? 0 : 2); end
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_step();
    endtask

    task automatic test_random();
        logic              e_g0, e_g1, e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        reset_pulse();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(9) < 6, $urandom_range(1) == 1, ADDR_W'($urandom_range(7)), $urandom,
                  $urandom_range(9) < 6, $urandom_range(1) == 1, ADDR_W'($urandom_range(7)), $urandom);
            e_g0   = (m_own == 0) && m0_req;
            e_g1   = (m_own == 1) && m1_req;
            e_we   = (e_g0 && m0_we) || (e_g1 && m1_we);
            e_addr = (m_own == 0) ? m0_addr : (m_own == 1) ? m1_addr : '0;
            e_wd   = (m_own == 0) ? m0_wdata : (m_own == 1) ? m1_wdata : '0;
            n_cmp++; if ({m0_gnt, m1_gnt, mem_we, cpu_stall} !== {e_g0, e_g1, e_we, m0_req && !e_g0}) begin
                n_fail++; $display("FAIL rand_ctl c=%0d got gnt=%b%b we=%b stall=%b exp %b%b %b %b", c,
                                   m0_gnt, m1_gnt, mem_we, cpu_stall, e_g0, e_g1, e_we, m0_req && !e_g0);
            end
            n_cmp++; if (mem_addr !== e_addr || mem_wdata !== e_wd) begin
                n_fail++; $display("FAIL rand_port c=%0d got %h/%h exp %h/%h", c, mem_addr, mem_wdata, e_addr, e_wd);
            end
            if (e_g0 && !m0_we) begin
                n_cmp++; if (m0_rdata !== ref_mem[m0_addr]) begin
                    n_fail++; $display("FAIL rand_rd0 c=%0d got %h exp %h", c, m0_rdata, ref_mem[m0_addr]);
                end
            end
            if (e_g1 && !m1_we) begin
                n_cmp++; if (m1_rdata !== ref_mem[m1_addr]) begin
                    n_fail++; $display("FAIL rand_rd1 c=%0d got %h exp %h", c, m1_rdata, ref_mem[m1_addr]);
                end
            end
            model_step();
        end
    endtask

    task automatic test_reset_mid_write();
        reset_pulse();
        drive(1, 1, 7'h09, 32'hCAFE_F00D, 0, 0, '0, '0);
        model_step();
        drive(1, 1, 7'h09, 32'hCAFE_F00D, 0, 0, '0, '0);
        n_cmp++; if (m0_gnt !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got gnt=%b we=%b exp 1 1", m0_gnt, mem_we); end
        arst_n = 1'b0;
        #1;
        n_cmp++; if (m0_gnt !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_drop got gnt=%b we=%b exp 0 0", m0_gnt, mem_we); end
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
        drive(1, 0, 7'h09, '0, 0, 0, '0, '0);
        model_step();
        drive(1, 0, 7'h09, '0, 0, 0, '0, '0);
        n_cmp++; if (m0_gnt !== 1'b1 || m0_rdata !== ref_mem[9]) begin
            n_fail++; $display("FAIL midrst_mem got gnt=%b rdata=%h exp 1 %h", m0_gnt, m0_rdata, ref_mem[9]);
        end
        model_step();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_step();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        arst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        model_reset();
        @(posedge clk);
        #1 mem_init = 1'b1;
        test_reset();
        test_single_master();
        test_tie();
        test_burst_cap();
        test_contention();
        test_random();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
